// File: rtl/servo_pkg.sv
// Shared constants and helpers for the multi-channel servo PWM block.
package servo_pkg;

  localparam int US_W        = 16;
  localparam int CTRL_ADDR   = 0;
  localparam int STATUS_ADDR = 1;
  localparam int CH_BASE     = 2;
  localparam int CH_STRIDE   = 2;

  function automatic logic [US_W-1:0] clampUs(input logic [US_W-1:0] v,
                                              input logic [US_W-1:0] lo,
                                              input logic [US_W-1:0] hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/servo_channel.sv
// One servo channel: clamped target, slew-limited current width and the
// registered pulse compare against the shared frame counter.
module servo_channel
  import servo_pkg::*;
#(
  parameter int MIN_US    = 1000,
  parameter int MAX_US    = 2000,
  parameter int CENTER_US = 1500
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            frameStart_i,
  input  logic            enable_i,
  input  logic [US_W-1:0] frameCnt_i,
  input  logic            wrTarget_i,
  input  logic            wrSlew_i,
  input  logic [US_W-1:0] wdata_i,
  output logic [US_W-1:0] target_o,
  output logic [US_W-1:0] slew_o,
  output logic            atTarget_o,
  output logic            pwm_o
);

  logic [US_W-1:0] target_q, target_d;
  logic [US_W-1:0] slew_q, slew_d;
  logic [US_W-1:0] current_q, current_d;
  logic            pwm_q, pwm_d;
  logic signed [US_W:0] diff, absDiff, slewExt;

  // The frame update reads target_q, so a write landing on frame_start waits a frame.
  always_comb begin
    diff      = $signed({1'b0, target_q}) - $signed({1'b0, current_q});
    absDiff   = (diff < 0) ? -diff : diff;
    slewExt   = $signed({1'b0, slew_q});
    target_d  = wrTarget_i ? clampUs(wdata_i, US_W'(MIN_US), US_W'(MAX_US)) : target_q;
    slew_d    = wrSlew_i ? wdata_i : slew_q;
    current_d = current_q;
    if (frameStart_i) begin
      if (slew_q == '0 || absDiff <= slewExt) begin
        current_d = target_q;
      end else if (diff < 0) begin
        current_d = current_q - slew_q;
      end else begin
        current_d = current_q + slew_q;
      end
    end
    pwm_d = enable_i && (frameCnt_i < current_q);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      target_q  <= US_W'(CENTER_US);
      slew_q    <= '0;
      current_q <= US_W'(CENTER_US);
      pwm_q     <= 1'b0;
    end else begin
      target_q  <= target_d;
      slew_q    <= slew_d;
      current_q <= current_d;
      pwm_q     <= pwm_d;
    end
  end

  assign target_o   = target_q;
  assign slew_o     = slew_q;
  assign atTarget_o = (current_q == target_q);
  assign pwm_o      = pwm_q;

endmodule

// File: rtl/servo_pwm_multi.sv
// N-channel servo PWM generator behind an Avalon-MM slave: timebase,
// enable, register decode and registered readback.
module servo_pwm_multi
  import servo_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CLKS_PER_US = 50,
  parameter int PERIOD_US   = 20000,
  parameter int MIN_US      = 1000,
  parameter int MAX_US      = 2000,
  parameter int CENTER_US   = 1500,
  parameter int ADDR_W      = 6
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  output logic [31:0]       avs_readdata,
  output logic [NUM_CH-1:0] servo_out
);

  localparam int PW = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
  localparam logic [PW-1:0]   PRESC_LAST = PW'(CLKS_PER_US - 1);
  localparam logic [US_W-1:0] FRAME_LAST = US_W'(PERIOD_US - 1);

  logic              enable_q, enable_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic [US_W-1:0]   frame_q, frame_d;
  logic [31:0]       rdData_q, rdData_d;
  logic              tick, frameStart, ctrlWr;
  logic [NUM_CH-1:0] wrTarget, wrSlew, atTarget, pwm;
  logic [US_W-1:0]   chTarget [NUM_CH];
  logic [US_W-1:0]   chSlew   [NUM_CH];
  logic              unusedWdata;

  assign ctrlWr     = avs_write && (avs_address == ADDR_W'(CTRL_ADDR));
  assign tick       = enable_q && (presc_q == PRESC_LAST);
  assign frameStart = tick && (frame_q == FRAME_LAST);
  assign unusedWdata = ^avs_writedata[31:US_W];

  // While disabled the timebase sits at zero so a re-enable always starts a fresh frame.
  always_comb begin
    enable_d = ctrlWr ? avs_writedata[0] : enable_q;
    presc_d  = '0;
    frame_d  = '0;
    if (enable_q) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
      frame_d = frame_q;
      if (tick) begin
        frame_d = (frame_q == FRAME_LAST) ? '0 : frame_q + US_W'(1);
      end
    end
  end

  always_comb begin
    rdData_d = rdData_q;
    if (avs_read) begin
      rdData_d = '0;
      if (avs_address == ADDR_W'(CTRL_ADDR))   rdData_d = {31'b0, enable_q};
      if (avs_address == ADDR_W'(STATUS_ADDR)) rdData_d = 32'(atTarget);
      for (int i = 0; i < NUM_CH; i++) begin
        if (avs_address == ADDR_W'(CH_BASE + CH_STRIDE * i))     rdData_d = 32'(chTarget[i]);
        if (avs_address == ADDR_W'(CH_BASE + CH_STRIDE * i + 1)) rdData_d = 32'(chSlew[i]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      enable_q <= 1'b0;
      presc_q  <= '0;
      frame_q  <= '0;
      rdData_q <= '0;
    end else begin
      enable_q <= enable_d;
      presc_q  <= presc_d;
      frame_q  <= frame_d;
      rdData_q <= rdData_d;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : gCh
    assign wrTarget[g] = avs_write && (avs_address == ADDR_W'(CH_BASE + CH_STRIDE * g));
    assign wrSlew[g]   = avs_write && (avs_address == ADDR_W'(CH_BASE + CH_STRIDE * g + 1));

    servo_channel #(
      .MIN_US    (MIN_US),
      .MAX_US    (MAX_US),
      .CENTER_US (CENTER_US)
    ) uChannel (
      .clk          (clk),
      .reset_n      (reset_n),
      .frameStart_i (frameStart),
      .enable_i     (enable_q),
      .frameCnt_i   (frame_q),
      .wrTarget_i   (wrTarget[g]),
      .wrSlew_i     (wrSlew[g]),
      .wdata_i      (avs_writedata[US_W-1:0]),
      .target_o     (chTarget[g]),
      .slew_o       (chSlew[g]),
      .atTarget_o   (atTarget[g]),
      .pwm_o        (pwm[g])
    );
  end

  assign avs_readdata = rdData_q;
  assign servo_out    = pwm;

endmodule

// File: tb/tb_servo_pwm_multi.sv
// Bench for servo_pwm_multi in a shrunken timebase: a cycle-level model of the
// register map and pulse rules is compared every cycle, plus directed literal checks.
module tb_servo_pwm_multi;

  localparam int NUM_CH    = 4;
  localparam int CLKS      = 1;
  localparam int PER       = 100;
  localparam int MINU      = 10;
  localparam int MAXU      = 50;
  localparam int CEN       = 30;
  localparam int AW        = 6;
  localparam int FRAME_CYC = CLKS * PER;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [AW-1:0]     avs_address = '0;
  logic              avs_read = 1'b0;
  logic              avs_write = 1'b0;
  logic [31:0]       avs_writedata = '0;
  logic [31:0]       avs_readdata;
  logic [NUM_CH-1:0] servo_out;

  int checks = 0;
  int failures = 0;
  bit checkEn = 1'b0;
  int cycleCount = 0;

  bit                mEn;
  int                mCyc;
  int                mTarget [NUM_CH];
  int                mSlew   [NUM_CH];
  int                mCur    [NUM_CH];
  logic [NUM_CH-1:0] mOut;
  logic [31:0]       mRd;

  servo_pwm_multi #(
    .NUM_CH      (NUM_CH),
    .CLKS_PER_US (CLKS),
    .PERIOD_US   (PER),
    .MIN_US      (MINU),
    .MAX_US      (MAXU),
    .CENTER_US   (CEN),
    .ADDR_W      (AW)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .avs_address   (avs_address),
    .avs_read      (avs_read),
    .avs_write     (avs_write),
    .avs_writedata (avs_writedata),
    .avs_readdata  (avs_readdata),
    .servo_out     (servo_out)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int clampModel(int v);
    return (v < MINU) ? MINU : ((v > MAXU) ? MAXU : v);
  endfunction

  function automatic logic [31:0] modelRead(int a);
    logic [31:0] r;
    r = '0;
    if (a == 0) r[0] = mEn;
    else if (a == 1) begin
      for (int i = 0; i < NUM_CH; i++) r[i] = (mCur[i] == mTarget[i]);
    end else if (a >= 2 && a < 2 + 2 * NUM_CH) begin
      r = ((a % 2) == 0) ? 32'(mTarget[(a - 2) / 2]) : 32'(mSlew[(a - 2) / 2]);
    end
    return r;
  endfunction

  // Model of the block as seen from outside: cycles elapsed since enable give the frame position.
  always @(posedge clk) begin : model
    int pos;
    bit fs;
    int d;
    int a;
    cycleCount++;
    if (!reset_n) begin
      mEn = 1'b0;
      mCyc = 0;
      mOut = '0;
      mRd = '0;
      for (int i = 0; i < NUM_CH; i++) begin
        mTarget[i] = CEN;
        mSlew[i] = 0;
        mCur[i] = CEN;
      end
    end else begin
      pos = (mCyc / CLKS) % PER;
      fs = mEn && ((mCyc % FRAME_CYC) == FRAME_CYC - 1);
      for (int i = 0; i < NUM_CH; i++) mOut[i] = mEn && (pos < mCur[i]);
      a = int'(avs_address);
      if (avs_read) mRd = modelRead(a);
      if (fs) begin
        for (int i = 0; i < NUM_CH; i++) begin
          d = mTarget[i] - mCur[i];
          if (mSlew[i] == 0 || (d < 0 ? -d : d) <= mSlew[i]) mCur[i] = mTarget[i];
          else mCur[i] = mCur[i] + ((d < 0) ? -mSlew[i] : mSlew[i]);
        end
      end
      mCyc = mEn ? (mCyc + 1) % FRAME_CYC : 0;
      if (avs_write) begin
        if (a == 0) mEn = avs_writedata[0];
        else if (a >= 2 && a < 2 + 2 * NUM_CH) begin
          if ((a % 2) == 0) mTarget[(a - 2) / 2] = clampModel(int'(avs_writedata[15:0]));
          else mSlew[(a - 2) / 2] = int'(avs_writedata[15:0]);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic timeoutFail(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s: got timeout expected event", name);
  endtask

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("servo_out", 32'(servo_out), 32'(mOut));
      checkOutput("readdata", avs_readdata, mRd);
    end
  end

  // Call at a negedge; drives one bus cycle and returns at the following negedge.
  task automatic applyStimulus(input bit wr, input bit rd, input int addr, input logic [31:0] data);
    avs_write = wr;
    avs_read = rd;
    avs_address = AW'(addr);
    avs_writedata = data;
    @(negedge clk);
    avs_write = 1'b0;
    avs_read = 1'b0;
  endtask

  task automatic busRead(input int addr, output logic [31:0] d);
    applyStimulus(1'b0, 1'b1, addr, 32'd0);
    d = avs_readdata;
  endtask

  task automatic waitPos(input int p);
    int k;
    k = 0;
    while (!(mEn && mCyc == p) && k < 3 * FRAME_CYC) begin
      @(negedge clk);
      k++;
    end
    if (k >= 3 * FRAME_CYC) timeoutFail("waitPos");
  endtask

  task automatic measurePulse(input int ch, output int width, output int rise);
    int k;
    k = 0;
    width = 0;
    rise = 0;
    while (servo_out[ch] !== 1'b1 && k < 3 * FRAME_CYC) begin
      @(negedge clk);
      k++;
    end
    if (k >= 3 * FRAME_CYC) timeoutFail("pulseRise");
    else begin
      rise = cycleCount;
      while (servo_out[ch] === 1'b1 && width <= FRAME_CYC) begin
        width++;
        @(negedge clk);
      end
    end
  endtask

  initial begin
    logic [31:0] rd;
    int w;
    int r1;
    int r2;
    int c0;
    int highs;

    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    checkEn = 1'b1;

    busRead(0, rd);  checkOutput("reset CTRL", rd, 32'd0);
    busRead(2, rd);  checkOutput("reset TARGET_0", rd, 32'(CEN));
    busRead(3, rd);  checkOutput("reset SLEW_0", rd, 32'd0);
    highs = 0;
    for (int i = 0; i < 200 * PER; i++) begin
      if (servo_out != '0) highs++;
      @(negedge clk);
    end
    checkOutput("idle highs", 32'(highs), 32'd0);

    applyStimulus(1'b1, 1'b0, 0, 32'd1);
    checkOutput("first pulse pre", 32'(servo_out[0]), 32'd0);
    for (int ch = 0; ch < NUM_CH; ch++) begin
      measurePulse(ch, w, r1);
      checkOutput("center width", 32'(w), 32'(CEN));
    end
    measurePulse(0, w, r1);
    measurePulse(0, w, r2);
    checkOutput("frame period", 32'(r2 - r1), 32'(FRAME_CYC));

    waitPos(50);
    applyStimulus(1'b1, 1'b0, 4, 32'd5);
    busRead(4, rd);  checkOutput("clamp low", rd, 32'(MINU));
    applyStimulus(1'b1, 1'b0, 4, 32'd999);
    busRead(4, rd);  checkOutput("clamp high", rd, 32'(MAXU));
    measurePulse(1, w, r1);
    checkOutput("ch1 width", 32'(w), 32'(MAXU));

    waitPos(50);
    applyStimulus(1'b1, 1'b0, 7, 32'd7);
    applyStimulus(1'b1, 1'b0, 6, 32'd50);
    busRead(1, rd);  checkOutput("status2 pre", 32'(rd[2]), 32'd0);
    measurePulse(2, w, r1);  checkOutput("slew width 1", 32'(w), 32'd37);
    busRead(1, rd);  checkOutput("status2 f1", 32'(rd[2]), 32'd0);
    measurePulse(2, w, r1);  checkOutput("slew width 2", 32'(w), 32'd44);
    busRead(1, rd);  checkOutput("status2 f2", 32'(rd[2]), 32'd0);
    measurePulse(2, w, r1);  checkOutput("slew width 3", 32'(w), 32'd50);
    busRead(1, rd);  checkOutput("status2 f3", 32'(rd[2]), 32'd1);

    waitPos(FRAME_CYC - 1);
    applyStimulus(1'b1, 1'b0, 2, 32'd45);
    measurePulse(0, w, r1);  checkOutput("fs write old", 32'(w), 32'd30);
    measurePulse(0, w, r1);  checkOutput("fs write new", 32'(w), 32'd45);

    applyStimulus(1'b1, 1'b0, 40, 32'd7);
    applyStimulus(1'b1, 1'b0, 1, 32'hF);
    busRead(4, rd);  checkOutput("readback ch1", rd, 32'd50);
    busRead(63, rd); checkOutput("unmapped read", rd, 32'd0);

    waitPos(10);
    checkOutput("mid pulse high", 32'(servo_out[0]), 32'd1);
    reset_n = 1'b0;
    @(negedge clk);
    checkOutput("reset drop", 32'(servo_out), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    busRead(2, rd);  checkOutput("TARGET_0 after reset", rd, 32'(CEN));

    applyStimulus(1'b1, 1'b0, 0, 32'd1);
    c0 = cycleCount;
    measurePulse(0, w, r1);
    checkOutput("enable rise lag", 32'(r1 - c0), 32'd1);
    checkOutput("enable width", 32'(w), 32'(CEN));
    waitPos(10);
    applyStimulus(1'b1, 1'b0, 0, 32'd0);
    @(negedge clk);
    checkOutput("disable drop", 32'(servo_out), 32'd0);
    repeat (5) @(negedge clk);
    applyStimulus(1'b1, 1'b0, 0, 32'd1);
    c0 = cycleCount;
    measurePulse(0, w, r1);
    checkOutput("reenable rise lag", 32'(r1 - c0), 32'd1);
    checkOutput("reenable width", 32'(w), 32'(CEN));

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
